mac_accumulator: RTL and testbench
==================================

Name: mac_accumulator

Overview:
- Time-multiplexed MAC accumulation stage, directly downstream of the fixed-point multiplier in the time-multiplexed filter datapath.
- Sequences NTAPS tap cycles and drives the tap index to the upstream sample/coefficient selection.
- Sums the multiplier's signed products at full precision with guard bits.
- Emits one rounded/saturated filter output sample per start request, with a valid pulse and an overflow flag.

Parameters:
- WIP, 2, integer bits of incoming product (matches multiplier output WIO)
- WFP, 6, fraction bits of incoming product (matches multiplier output WFO)
- NTAPS, 8, number of products summed per output sample (>=1)
- WIO, 2, integer bits of output sample
- WFO, 6, fraction bits of output sample

Ports:
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous active-low reset
- start  in  1  request a new output sample; accepted only in IDLE
- inMult  in  WIP+WFP  signed product from multiplier, sampled every ACCUM cycle
- tapIdx  out  max(1,$clog2(NTAPS))  current tap index driven to the upstream selector; registered
- busy  out  1  high while state != IDLE
- outData  out  WIO+WFO  signed result; holds until the next DONE
- outValid  out  1  one-cycle pulse when outData updates
- ovf  out  1  set when this sample saturated; valid with outValid, held with outData

Behaviour:
- Reset (RST=0, async): state=IDLE, acc=0, tapIdx=0, busy=0, outData=0, outValid=0, ovf=0.
- Guard bits G=$clog2(NTAPS); acc width WIP+G+WFP signed, fraction WFP. Accumulation cannot overflow.
- FSM IDLE/ACCUM/DONE, all transitions on the rising CLK edge.
- IDLE: start=1 -> acc<=0, tapIdx<=0, busy<=1, state<=ACCUM. start=0 -> stay in IDLE.
- ACCUM: acc<=acc+sign-extended inMult. If tapIdx==NTAPS-1 -> state<=DONE, else tapIdx<=tapIdx+1. Exactly NTAPS products are summed; inMult is sampled during the cycle tapIdx=k (multiplier is combinational).
- DONE: outData<=convert(acc), ovf<=overflow, outValid<=1, tapIdx<=0, busy<=0, state<=IDLE. outValid is low in every other cycle.
- Latency: start sampled at edge 0 -> outValid high after edge NTAPS+1. Throughput is one sample per NTAPS+2 cycles.
- start while busy (ACCUM or DONE) is ignored. It is not queued.
- NTAPS=1: one ACCUM cycle, tapIdx constant 0.
- Conversion, fraction:
  - WFO>=WFP: append zeros.
  - WFO<WFP: drop the LSBs by truncation (see optional feature).
- Conversion, integer:
  - If the value fits in WIO integer bits, copy it.
  - Otherwise saturate to the most positive (0111..1) or most negative (1000..0) value and set ovf=1.
  - A round-up carry that exceeds the range also saturates.
- Reset mid-operation aborts immediately. No outValid is produced for the aborted sample.

Optional Feature:
- Macro MAC_ACC_ROUND_EN.
- Defined: when WFO<WFP, add 2^(WFP-WFO-1) (half output LSB, round-half-up) to acc before dropping the LSBs, then saturate.
- Undefined: truncate toward minus infinity.
- No effect when WFO>=WFP.

Decomposition:
- Shared package filt_pkg holds:
  - mac_state_t enum (IDLE, ACCUM, DONE)
  - function for guard-bit count
  - saturation max/min constant helpers, reused by multiplier and accumulator
- One sub-module, fx_sat_round: combinational width converter (in format to out format, rounding under macro, saturation, ovf). Instantiated once on the acc-to-outData path.

Test Plan (defaults except NTAPS=4; Q2.6 in/out):
- Four products 0x10 (0.25) -> outData=0x40 (1.0), ovf=0; outValid pulses exactly 5 cycles after start; tapIdx reads 0,1,2,3 during ACCUM.
- Four products 0x7F -> sum +7.94 -> outData=0x7F, ovf=1. Four products 0x80 -> -8.0 -> outData=0x80, ovf=1.
- Products 0x40, 0xC0, 0x20, 0xF0 -> outData=0x10, ovf=0. The following sample with all 0x00 -> outData=0x00, ovf cleared.
- Second start pulse at tapIdx=1 -> ignored: single outValid, busy stays high through DONE, result unchanged.
- RST low during ACCUM at tapIdx=2 -> busy, outValid, outData, tapIdx all 0 asynchronously. After release, a fresh start gives the correct result.
- WFO=4, products 0x01, 0x01, 0x01, 0x00 (sum 3/64):
  - macro undefined -> outData=0x00
  - MAC_ACC_ROUND_EN defined -> outData=0x01

Source files
------------

// File: rtl/filt_pkg.sv
// Shared definitions for the time-multiplexed filter datapath.
//   mac_state_t       : state encoding of the MAC accumulation sequencer
//   guard_bits(n)     : extra integer bits needed to sum n products without overflow
//   tap_width(n)      : width of a tap index counting 0..n-1 (at least 1 bit)
//   sat_max/sat_min(w): most positive / most negative w-bit two's-complement patterns
package filt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } mac_state_t;

    function automatic int guard_bits(input int n);
        return (n <= 1) ? 0 : $clog2(n);
    endfunction

    function automatic int tap_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Callers cast the result down to their own word width.
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/fx_sat_round.sv
// Combinational signed fixed-point width converter.
//   in_data  : signed input, WII integer bits + WFI fraction bits
//   out_data : signed output, WIO integer bits + WFO fraction bits
//   ovf      : high when the value did not fit and out_data was saturated
// Fraction: zero-padded when widening; when narrowing the dropped LSBs are
// truncated (floor), or rounded half-up when MAC_ACC_ROUND_EN is defined.
// Integer: saturates to the most positive / most negative output code.
module fx_sat_round
    import filt_pkg::*;
#(
    parameter int WII = 2,
    parameter int WFI = 6,
    parameter int WIO = 2,
    parameter int WFO = 6
) (
    input  logic [WII+WFI-1:0] in_data,
    output logic [WIO+WFO-1:0] out_data,
    output logic               ovf
);

    localparam int WOUT = WIO + WFO;
    // One extra integer bit absorbs a rounding carry out of the top.
    localparam int WX   = WII + 1 + WFO;

    localparam logic [WOUT-1:0] SAT_MAX = WOUT'(sat_max(WOUT));
    localparam logic [WOUT-1:0] SAT_MIN = WOUT'(sat_min(WOUT));

    // Input re-expressed with WFO fraction bits.
    logic signed [WX-1:0] aligned;

    generate
        if (WFO >= WFI) begin : g_pad
            logic signed [WX-1:0] ext;
            assign ext     = WX'($signed(in_data));
            assign aligned = ext <<< (WFO - WFI);
        end else begin : g_drop
            localparam int SH = WFI - WFO;
            localparam int WE = WII + 1 + WFI;
            logic signed [WE-1:0] ext;
            logic signed [WE-1:0] biased;
            logic                 unused_lsbs;
            assign ext = WE'($signed(in_data));
`ifdef MAC_ACC_ROUND_EN
            // Half an output LSB: round half up before dropping bits.
            assign biased = ext + WE'(1 << (SH - 1));
`else
            assign biased = ext;
`endif
            // Taking the upper slice of a two's-complement value is a floor.
            assign aligned     = biased[WE-1:SH];
            assign unused_lsbs = ^biased[SH-1:0];
        end

        if (WX > WOUT) begin : g_sat
            // Fits iff every bit from the output sign bit upward agrees.
            logic [WX-WOUT:0] top_bits;
            logic             fits;
            assign top_bits = aligned[WX-1:WOUT-1];
            assign fits     = (&top_bits) | ~(|top_bits);
            assign out_data = fits ? aligned[WOUT-1:0]
                                   : (aligned[WX-1] ? SAT_MIN : SAT_MAX);
            assign ovf      = ~fits;
        end else begin : g_fit
            assign out_data = WOUT'(aligned);
            assign ovf      = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/mac_accumulator.sv
// Time-multiplexed MAC accumulation stage.
//   CLK      : rising-edge clock
//   RST      : asynchronous active-low reset
//   start    : request one output sample (accepted only when idle)
//   inMult   : signed product from the multiplier, Q(WIP).(WFP)
//   tapIdx   : registered tap index driven to the upstream selector
//   busy     : high while a sample is in progress
//   outData  : signed result Q(WIO).(WFO), held until the next result
//   outValid : one-cycle pulse when outData updates
//   ovf      : result saturated; updates with outData
// Build option: define MAC_ACC_ROUND_EN to round half-up instead of
// truncating when WFO < WFP.
module mac_accumulator
    import filt_pkg::*;
#(
    parameter int WIP   = 2,
    parameter int WFP   = 6,
    parameter int NTAPS = 8,
    parameter int WIO   = 2,
    parameter int WFO   = 6
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        start,
    input  logic [WIP+WFP-1:0]          inMult,
    output logic [tap_width(NTAPS)-1:0] tapIdx,
    output logic                        busy,
    output logic [WIO+WFO-1:0]          outData,
    output logic                        outValid,
    output logic                        ovf
);

    localparam int G    = guard_bits(NTAPS);
    localparam int WA   = WIP + G + WFP;
    localparam int TW   = tap_width(NTAPS);
    localparam int WOUT = WIO + WFO;
    localparam logic [TW-1:0] LAST_TAP = TW'(NTAPS - 1);

    mac_state_t           state_reg;
    logic signed [WA-1:0] acc_reg;
    logic [WOUT-1:0]      conv_data;
    logic                 conv_ovf;

    fx_sat_round #(
        .WII (WIP + G),
        .WFI (WFP),
        .WIO (WIO),
        .WFO (WFO)
    ) u_conv (
        .in_data  (acc_reg),
        .out_data (conv_data),
        .ovf      (conv_ovf)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            tapIdx    <= '0;
            busy      <= 1'b0;
            outData   <= '0;
            outValid  <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            outValid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        acc_reg   <= '0;
                        tapIdx    <= '0;
                        busy      <= 1'b1;
                        state_reg <= ACCUM;
                    end
                end
                ACCUM: begin
                    // The multiplier is combinational, so inMult already
                    // reflects the product selected by the current tapIdx.
                    acc_reg <= acc_reg + WA'($signed(inMult));
                    if (tapIdx == LAST_TAP) begin
                        state_reg <= DONE;
                    end else begin
                        tapIdx <= tapIdx + TW'(1);
                    end
                end
                DONE: begin
                    outData   <= conv_data;
                    ovf       <= conv_ovf;
                    outValid  <= 1'b1;
                    tapIdx    <= '0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    tapIdx    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Self-checking bench for mac_accumulator.  Two instances share stimulus:
// dut (NTAPS=4, Q2.6 -> Q2.6) and dut4 (NTAPS=4, Q2.6 -> Q2.4, the
// fraction-narrowing path).  A timeline model predicts every output on every
// cycle; directed samples also carry hand-computed literal results.
module tb_mac_accumulator;

    localparam int NT = 4;

    logic       CLK = 1'b0;
    logic       RST;
    logic       start;
    logic [7:0] inMult;

    logic [1:0] tapIdx,   tapIdx4;
    logic       busy,     busy4;
    logic [7:0] outData;
    logic [5:0] outData4;
    logic       outValid, outValid4;
    logic       ovf,      ovf4;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 CLK = ~CLK;

    mac_accumulator #(.WIP(2), .WFP(6), .NTAPS(NT), .WIO(2), .WFO(6)) dut (
        .CLK(CLK), .RST(RST), .start(start), .inMult(inMult),
        .tapIdx(tapIdx), .busy(busy), .outData(outData),
        .outValid(outValid), .ovf(ovf)
    );

    mac_accumulator #(.WIP(2), .WFP(6), .NTAPS(NT), .WIO(2), .WFO(4)) dut4 (
        .CLK(CLK), .RST(RST), .start(start), .inMult(inMult),
        .tapIdx(tapIdx4), .busy(busy4), .outData(outData4),
        .outValid(outValid4), .ovf(ovf4)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Value arithmetic on plain integers in units of 2^-6.
    function automatic int conv_raw(input int s, input int wfo);
        int v;
        if (wfo >= 6) begin
            v = s <<< (wfo - 6);
        end else begin
`ifdef MAC_ACC_ROUND_EN
            s = s + (1 << (6 - wfo - 1));
`endif
            v = s >>> (6 - wfo);   // arithmetic shift of int = floor
        end
        return v;
    endfunction

    function automatic int conv_val(input int s, input int wfo);
        int v, lim;
        v   = conv_raw(s, wfo);
        lim = 1 << (2 + wfo - 1);
        if (v > lim - 1) v = lim - 1;
        if (v < -lim)    v = -lim;
        return v;
    endfunction

    function automatic bit conv_ovf(input int s, input int wfo);
        int v, lim;
        v   = conv_raw(s, wfo);
        lim = 1 << (2 + wfo - 1);
        return (v > lim - 1) || (v < -lim);
    endfunction

    // m_phase: -1 idle, 0..NT-1 = index of product being taken, NT = result cycle.
    int         m_phase;
    int         m_sum;
    bit         m_valid, m_ovf, m_ovf4;
    logic [7:0] m_data;
    logic [5:0] m_data4;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_phase <= -1;
            m_sum   <= 0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_ovf   <= 1'b0;
            m_data4 <= '0;
            m_ovf4  <= 1'b0;
        end else begin
            m_valid <= 1'b0;
            if (m_phase < 0) begin
                if (start) begin
                    m_phase <= 0;
                    m_sum   <= 0;
                end
            end else if (m_phase < NT) begin
                m_sum   <= m_sum + int'($signed(inMult));
                m_phase <= m_phase + 1;
            end else begin
                m_data  <= 8'(conv_val(m_sum, 6));
                m_ovf   <= conv_ovf(m_sum, 6);
                m_data4 <= 6'(conv_val(m_sum, 4));
                m_ovf4  <= conv_ovf(m_sum, 4);
                m_valid <= 1'b1;
                m_phase <= -1;
            end
        end
    end

    function automatic int exp_tap(input int ph);
        if (ph < 0)   return 0;
        if (ph >= NT) return NT - 1;
        return ph;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge CLK) begin
        if (cmp_en) begin
            chk("busy",      busy,      m_phase >= 0);
            chk("tapIdx",    tapIdx,    exp_tap(m_phase));
            chk("outValid",  outValid,  m_valid);
            chk("outData",   outData,   m_data);
            chk("ovf",       ovf,       m_ovf);
            chk("busy4",     busy4,     m_phase >= 0);
            chk("tapIdx4",   tapIdx4,   exp_tap(m_phase));
            chk("outValid4", outValid4, m_valid);
            chk("outData4",  outData4,  m_data4);
            chk("ovf4",      ovf4,      m_ovf4);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic run_sample(input string name,
                              input logic [7:0] p0, input logic [7:0] p1,
                              input logic [7:0] p2, input logic [7:0] p3,
                              input logic [7:0] e6, input bit o6,
                              input logic [5:0] e4, input bit o4,
                              input bit dup);
        logic [7:0] prod [4];
        int lat;
        prod[0] = p0; prod[1] = p1; prod[2] = p2; prod[3] = p3;
        lat = -1;
        @(negedge CLK);
        start = 1'b1;
        @(posedge CLK);                       // edge 0: start sampled
        for (int c = 1; c <= 12 && lat < 0; c++) begin
            @(negedge CLK);                   // c-1 edges after edge 0
            start = dup && (c == 2);          // extra start while tapIdx=1
            if (c <= NT) begin
                chk({name, ".tapIdx"}, tapIdx, c - 1);
                inMult = prod[c-1];
            end else begin
                inMult = 8'h00;
            end
            if (c == NT + 1) chk({name, ".busy_done"}, busy, 1);
            if (outValid) lat = c - 1;
        end
        chk({name, ".latency"}, lat, NT + 1);
        chk({name, ".data"},  outData,  e6);
        chk({name, ".ovf"},   ovf,      o6);
        chk({name, ".data4"}, outData4, e4);
        chk({name, ".ovf4"},  ovf4,     o4);
        $display("sample %s: outData=0x%02h ovf=%0d outData4=0x%02h ovf4=%0d latency=%0d",
                 name, outData, ovf, outData4, ovf4, lat);
        repeat (2) @(negedge CLK);
    endtask

    localparam logic [5:0] SMALL4 =
`ifdef MAC_ACC_ROUND_EN
        6'h01;
`else
        6'h00;
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        RST    = 1'b0;
        start  = 1'b0;
        inMult = 8'h00;
        repeat (3) @(negedge CLK);
        #1;
        chk("reset.busy",     busy,     0);
        chk("reset.tapIdx",   tapIdx,   0);
        chk("reset.outValid", outValid, 0);
        chk("reset.outData",  outData,  0);
        chk("reset.ovf",      ovf,      0);
        $display("reset: busy=%0d tapIdx=%0d outValid=%0d outData=0x%02h ovf=%0d",
                 busy, tapIdx, outValid, outData, ovf);
        RST    = 1'b1;
        cmp_en = 1'b1;
        repeat (2) @(negedge CLK);

        run_sample("quarter",  8'h10, 8'h10, 8'h10, 8'h10, 8'h40, 0, 6'h10, 0, 0);
        run_sample("pos_sat",  8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 1, 6'h1F, 1, 0);
        run_sample("neg_sat",  8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 1, 6'h20, 1, 0);
        run_sample("mixed",    8'h40, 8'hC0, 8'h20, 8'hF0, 8'h10, 0, 6'h04, 0, 0);
        run_sample("zeros",    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 6'h00, 0, 0);
        run_sample("dupstart", 8'h10, 8'h10, 8'h10, 8'h10, 8'h40, 0, 6'h10, 0, 1);
        run_sample("small",    8'h01, 8'h01, 8'h01, 8'h00, 8'h03, 0, SMALL4, 0, 0);
        run_sample("quarter2", 8'h10, 8'h10, 8'h10, 8'h10, 8'h40, 0, 6'h10, 0, 0);

        // Abort with reset in the tapIdx=2 cycle.
        @(negedge CLK);
        start = 1'b1;
        @(posedge CLK);
        for (int c = 1; c <= 3; c++) begin
            @(negedge CLK);
            start  = 1'b0;
            inMult = 8'h10;
        end
        chk("abort.tap_before", tapIdx, 2);
        #2 RST = 1'b0;
        #1;
        chk("abort.busy",     busy,     0);
        chk("abort.outValid", outValid, 0);
        chk("abort.outData",  outData,  0);
        chk("abort.tapIdx",   tapIdx,   0);
        chk("abort.outData4", outData4, 0);
        $display("abort: busy=%0d outValid=%0d outData=0x%02h tapIdx=%0d",
                 busy, outValid, outData, tapIdx);
        @(negedge CLK);
        #2 RST = 1'b1;
        inMult = 8'h00;
        repeat (2) @(negedge CLK);
        run_sample("after_rst", 8'h40, 8'hC0, 8'h20, 8'hF0, 8'h10, 0, 6'h04, 0, 0);

        repeat (3) @(negedge CLK);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
